// File: rtl/mm_pkg.sv
// Shared definitions for the Montgomery multiplier datapath: limb geometry,
// BRAM word width, limb-count helper and the loader FSM state encoding.
package mm_pkg;
   localparam int LIMB_W      = 17;
   localparam int BRAM_WORD_W = 32;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   // Limb count for a WIDTH-bit operand; must match the multiplier top.
   function automatic int calc_s(input int width);
      return (width + 1) / LIMB_W + 1;
   endfunction
endpackage

// File: rtl/mm_limb_slicer.sv
// Re-slices a 32-bit word stream into 17-bit limbs through a 48-bit bit buffer.
// Accept and emit are mutually exclusive by construction.
module mm_limb_slicer
   import mm_pkg::*;
#(
   parameter int N_WORDS = 8
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              clear,
   input  logic              active,
   input  logic              limbs_left,
   input  logic [31:0]       s_data,
   input  logic              s_valid,
   output logic              ready,
   output logic              emit,
   output logic [LIMB_W-1:0] limb
);
   localparam int WT_W = $clog2(N_WORDS + 1);

   logic [47:0]     bits_q;
   logic [5:0]      cnt_q;
   logic [WT_W-1:0] words_q;
   logic            all_taken;
   logic            take;

   assign all_taken = (words_q == WT_W'(N_WORDS));
   assign ready     = active && (cnt_q < 6'(LIMB_W)) && !all_taken;
   assign emit      = active && limbs_left && ((cnt_q >= 6'(LIMB_W)) || all_taken);
   assign take      = ready && s_valid;
   assign limb      = bits_q[LIMB_W-1:0];

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         bits_q  <= '0;
         cnt_q   <= '0;
         words_q <= '0;
      end else if (clear) begin
         bits_q  <= '0;
         cnt_q   <= '0;
         words_q <= '0;
      end else if (take) begin
         bits_q  <= bits_q | (48'(s_data) << cnt_q);
         cnt_q   <= cnt_q + 6'd32;
         words_q <= words_q + WT_W'(1);
      end else if (emit) begin
         // Once the stream is exhausted the count floors at zero, padding tail limbs.
         bits_q <= bits_q >> LIMB_W;
         cnt_q  <= (cnt_q >= 6'(LIMB_W)) ? cnt_q - 6'(LIMB_W) : 6'd0;
      end
   end
endmodule

// File: rtl/mm_operand_loader.sv
// Operand loader: streams 32-bit words in, writes one zero-extended 17-bit limb
// per BRAM word at byte address (base + index) << 2.
//   state | meaning
//   IDLE  | waiting for start_i; stream not accepted
//   LOAD  | accepting words and writing limbs 0..S-1
//   DONE  | one-cycle completion pulse, then back to IDLE
module mm_operand_loader
   import mm_pkg::*;
#(
   parameter int WIDTH = 256
) (
   input  logic        clock_i,
   input  logic        reset_n_i,
   input  logic        start_i,
   input  logic [31:0] base_addr_i,
   input  logic [31:0] s_data_i,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   output logic [31:0] BRAM_addr_o,
   output logic [31:0] BRAM_din_o,
   output logic [3:0]  BRAM_we_o,
   output logic        BRAM_en_o,
   output logic        busy_o,
   output logic        done_o
);
   localparam int S       = calc_s(WIDTH);
   localparam int N_WORDS = (WIDTH + 31) / 32;
   localparam int IDX_W   = $clog2(S + 1);

   state_t              state_q, state_d;
   logic [31:0]         base_q;
   logic [IDX_W-1:0]    idx_q;
   logic                start_acc;
   logic                active;
   logic                limbs_left;
   logic                emit;
   logic                wr_q;
   logic [LIMB_W-1:0]   limb;

   assign start_acc  = (state_q == IDLE) && start_i;
   assign limbs_left = (idx_q < IDX_W'(S));

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = LOAD;
         LOAD:    if (emit && (idx_q == IDX_W'(S - 1))) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      active = 1'b0;
      busy_o = 1'b0;
      done_o = 1'b0;
      case (state_q)
         LOAD: begin
            active = 1'b1;
            busy_o = 1'b1;
         end
         DONE: begin
            busy_o = 1'b1;
            done_o = 1'b1;
         end
         default: ;
      endcase
   end

   mm_limb_slicer #(.N_WORDS(N_WORDS)) u_slicer (
      .clock_i    (clock_i),
      .reset_n_i  (reset_n_i),
      .clear      (start_acc),
      .active     (active),
      .limbs_left (limbs_left),
      .s_data     (s_data_i),
      .s_valid    (s_valid_i),
      .ready      (s_ready_o),
      .emit       (emit),
      .limb       (limb)
   );

   // BRAM port is registered; address wraps modulo 2^32.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         base_q      <= '0;
         idx_q       <= '0;
         wr_q        <= 1'b0;
         BRAM_addr_o <= '0;
         BRAM_din_o  <= '0;
      end else begin
         wr_q <= emit;
         if (start_acc) begin
            base_q <= base_addr_i;
            idx_q  <= '0;
         end else if (emit) begin
            idx_q       <= idx_q + IDX_W'(1);
            BRAM_addr_o <= (base_q + 32'(idx_q)) << 2;
            BRAM_din_o  <= BRAM_WORD_W'(limb);
         end
      end
   end

   assign BRAM_en_o = wr_q;
   assign BRAM_we_o = {4{wr_q}};
endmodule
